// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store via req/ack; ack arrives LATENCY+1 cycles after grant.
// Held req without ack is a stall. Define ARB_ROUND_ROBIN_EN to alternate conflict grants (default: data port wins).
module mem_arbiter #(
    parameter int AW      = 64,
    parameter int DW      = 64,
    parameter int LATENCY = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ack,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ack,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_read,
    output logic          mem_write,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          we_q, we_d;
    logic          own_data_q, own_data_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          grant_data;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 = data port won the previous grant; resets to fetch so the first conflict goes to data
    logic last_data_q, last_data_d;
    assign grant_data = d_req && (!if_req || !last_data_q);
`else
    assign grant_data = d_req;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        own_data_d = own_data_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_data_d = last_data_q;
`endif
        case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    state_d    = ACCESS;
                    cnt_d      = CNT_INIT;
                    own_data_d = grant_data;
`ifdef ARB_ROUND_ROBIN_EN
                    last_data_d = grant_data;
`endif
                    if (grant_data) begin
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                        we_d    = d_we;
                    end else begin
                        addr_d  = if_addr;
                        wdata_d = '0;
                        we_d    = 1'b0;
                    end
                end
            end
            ACCESS: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    cnt_d   = 4'd0;
                    // Read data is captured on the last access edge into the owner's register only
                    if (!we_q) begin
                        if (own_data_q) begin
                            d_rdata_d = mem_rdata;
                        end else begin
                            if_rdata_d = mem_rdata;
                        end
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            own_data_q <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            own_data_q <= own_data_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            last_data_q <= 1'b0;
        end else begin
            last_data_q <= last_data_d;
        end
    end
`endif

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_read  = (state_q == ACCESS) && !we_q;
    assign mem_write = (state_q == ACCESS) && we_q;
    assign if_ack    = (state_q == RESP) && !own_data_q;
    assign d_ack     = (state_q == RESP) && own_data_q;
    assign busy      = (state_q != IDLE);
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule
